// File: rtl/arith_tb_pkg.sv
// Definitions shared by the arithmetic test harness: reference operation codes,
// one-hot monitor states and the "delay unknown" sentinel used by driver and monitor.
package arith_tb_pkg;

  localparam int unsigned OP_ADD = 0;
  localparam int unsigned OP_SUB = 1;
  localparam int unsigned OP_MUL = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_FILL  = 3'b010,
    ST_CHECK = 3'b100
  } mon_state_e;

  // All-ones of a k-bit delay field marks the DUT latency as not yet measured.
  function automatic int unsigned delay_unknown(input int unsigned k);
    return (32'd1 << k) - 32'd1;
  endfunction

endpackage

// File: rtl/result_monitor_expect_delay_line.sv
// History of expected results, one entry per clock, with a variable read tap.
// hist[0] holds the value written on the most recent edge.
module expect_delay_line #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned K     = 4
) (
  input  logic             clk_dut,
  input  logic [WIDTH-1:0] din,
  input  logic [K-1:0]     rd_idx,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned DEPTH = (1 << K) - 1;

  logic [DEPTH-1:0][WIDTH-1:0] hist;

  always_ff @(posedge clk_dut) begin
    hist <= {hist[DEPTH-2:0], din};
  end

  // The all-ones index lies past the last entry and reads as zero.
  always_comb begin
    dout = '0;
    if (32'(rd_idx) < DEPTH) dout = hist[rd_idx];
  end

endmodule

// File: rtl/result_monitor.sv
// Receive-side checker: rebuilds expected results from the driven operands, aligns
// them to the measured DUT latency and tracks check/error counts and the first mismatch.
module result_monitor
  import arith_tb_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned K          = 4,
  parameter int unsigned OP         = 0,
  parameter int unsigned PASS_COUNT = 1024
) (
  input  logic             clk_dut,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_drive_a,
  input  logic [WIDTH-1:0] i_drive_b,
  input  logic [WIDTH-1:0] i_dut_out,
  input  logic [K-1:0]     i_dut_delay,
  output logic [2:0]       o_state,
  output logic [31:0]      o_check_count,
  output logic [15:0]      o_error_count,
  output logic             o_pass,
  output logic             o_fail,
  output logic [WIDTH-1:0] o_first_exp,
  output logic [WIDTH-1:0] o_first_got
);

  localparam logic [K-1:0] DLY_UNKNOWN = K'(delay_unknown(K));

  mon_state_e       state;
  logic [K-1:0]     d_lat;
  logic [K-1:0]     fill_cnt;
  logic [31:0]      check_count;
  logic [15:0]      error_count;
  logic             fail;
  logic [WIDTH-1:0] first_exp;
  logic [WIDTH-1:0] first_got;

  logic [WIDTH-1:0] exp_live;
  logic [WIDTH-1:0] exp_tap;
  logic [WIDTH-1:0] exp_sel;
  logic [K-1:0]     tap_idx;
  logic             dly_valid;
  logic             dly_break;
  logic             do_cmp;
  logic             mismatch;

  always_comb begin
    case (OP)
      OP_SUB:  exp_live = i_drive_a - i_drive_b;
      OP_MUL:  exp_live = i_drive_a * i_drive_b;
      default: exp_live = i_drive_a + i_drive_b;
    endcase
  end

  assign tap_idx = d_lat - K'(1);

  expect_delay_line #(
    .WIDTH(WIDTH),
    .K    (K)
  ) u_hist (
    .clk_dut(clk_dut),
    .din    (exp_live),
    .rd_idx (tap_idx),
    .dout   (exp_tap)
  );

  // The last FILL edge (fill_cnt == 0) already compares, so the first check lands
  // D+1 edges after the IDLE->FILL edge.
  always_comb begin
    dly_valid = (i_dut_delay != DLY_UNKNOWN);
    dly_break = !dly_valid || (i_dut_delay != d_lat);
    do_cmp    = !dly_break &&
                ((state == ST_CHECK) || ((state == ST_FILL) && (fill_cnt == '0)));
    exp_sel   = (d_lat == '0) ? exp_live : exp_tap;
    mismatch  = do_cmp && (i_dut_out != exp_sel);
  end

  always_ff @(posedge clk_dut) begin
    if (reset) begin
      state       <= ST_IDLE;
      d_lat       <= '0;
      fill_cnt    <= '0;
      check_count <= '0;
      error_count <= '0;
      fail        <= 1'b0;
      first_exp   <= '0;
      first_got   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (dly_valid) begin
            d_lat    <= i_dut_delay;
            fill_cnt <= i_dut_delay;
            state    <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (dly_break)              state    <= ST_IDLE;
          else if (fill_cnt == '0)    state    <= ST_CHECK;
          else                        fill_cnt <= fill_cnt - K'(1);
        end
        ST_CHECK: begin
          if (dly_break) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (do_cmp && (check_count != '1)) check_count <= check_count + 32'd1;
      if (mismatch) begin
        if (error_count != '1) error_count <= error_count + 16'd1;
        if (!fail) begin
          fail      <= 1'b1;
          first_exp <= exp_sel;
          first_got <= i_dut_out;
        end
      end
    end
  end

  assign o_state       = state;
  assign o_check_count = check_count;
  assign o_error_count = error_count;
  assign o_fail        = fail;
  assign o_first_exp   = first_exp;
  assign o_first_got   = first_got;
  assign o_pass        = (check_count >= 32'(PASS_COUNT)) && (error_count == '0);

endmodule

// File: tb/tb_result_monitor.sv
// Directed bench for result_monitor: an adder and a subtractor monitor fed by a
// bench-side fake DUT, checked every cycle against an edge-indexed reference model.
module tb_result_monitor;
  import arith_tb_pkg::*;

  localparam int unsigned W = 32;
  localparam int unsigned K = 4;
  localparam logic [K-1:0] UNK = 4'hF;

  logic clk_dut = 1'b0;
  always #5 clk_dut = ~clk_dut;

  logic          reset;
  logic [W-1:0]  a, b;
  logic [K-1:0]  dly;
  logic [W-1:0]  dout [2];
  logic [2:0]    st   [2];
  logic [31:0]   cc   [2];
  logic [15:0]   ec   [2];
  logic          pass [2];
  logic          fl   [2];
  logic [W-1:0]  fe   [2];
  logic [W-1:0]  fg   [2];

  result_monitor #(.WIDTH(W), .K(K), .OP(OP_ADD), .PASS_COUNT(1024)) dut_add (
    .clk_dut(clk_dut), .reset(reset), .i_drive_a(a), .i_drive_b(b),
    .i_dut_out(dout[0]), .i_dut_delay(dly), .o_state(st[0]), .o_check_count(cc[0]),
    .o_error_count(ec[0]), .o_pass(pass[0]), .o_fail(fl[0]),
    .o_first_exp(fe[0]), .o_first_got(fg[0]));

  result_monitor #(.WIDTH(W), .K(K), .OP(OP_SUB), .PASS_COUNT(1024)) dut_sub (
    .clk_dut(clk_dut), .reset(reset), .i_drive_a(a), .i_drive_b(b),
    .i_dut_out(dout[1]), .i_dut_delay(dly), .o_state(st[1]), .o_check_count(cc[1]),
    .o_error_count(ec[1]), .o_pass(pass[1]), .o_fail(fl[1]),
    .o_first_exp(fe[1]), .o_first_got(fg[1]));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input int i, input logic [W-1:0] x, input logic [W-1:0] y);
    return (i == 0) ? x + y : x - y;
  endfunction

  // Reference model: E(n) per edge; output at edge n is checked against E(n-D)
  // once D+1 edges have passed since the delay was accepted while stable.
  int unsigned edge_n = 0;
  logic [W-1:0] eh [2][16];
  bit           m_armed [2];
  int unsigned  m_d [2];
  int unsigned  m_arm [2];
  logic [31:0]  m_cc [2];
  logic [15:0]  m_ec [2];
  bit           m_fl [2];
  logic [W-1:0] m_fe [2];
  logic [W-1:0] m_fg [2];

  initial begin
    logic [W-1:0] ex;
    logic [2:0]   xs;
    for (int i = 0; i < 2; i++) begin
      m_armed[i] = 0; m_cc[i] = '0; m_ec[i] = '0; m_fl[i] = 0; m_fe[i] = '0; m_fg[i] = '0;
    end
    forever begin
      @(posedge clk_dut);
      for (int i = 0; i < 2; i++) begin
        eh[i][4'(edge_n)] = ref_op(i, a, b);
        if (reset) begin
          m_armed[i] = 0; m_cc[i] = '0; m_ec[i] = '0; m_fl[i] = 0; m_fe[i] = '0; m_fg[i] = '0;
        end else if (!m_armed[i]) begin
          if (dly !== UNK) begin
            m_armed[i] = 1; m_d[i] = 32'(dly); m_arm[i] = edge_n;
          end
        end else if (32'(dly) != m_d[i]) begin
          m_armed[i] = 0;
        end else if (edge_n >= m_arm[i] + m_d[i] + 1) begin
          ex = eh[i][4'(edge_n - m_d[i])];
          if (m_cc[i] != '1) m_cc[i] = m_cc[i] + 1;
          if (dout[i] !== ex) begin
            if (m_ec[i] != 16'hFFFF) m_ec[i] = m_ec[i] + 1;
            if (!m_fl[i]) begin m_fl[i] = 1; m_fe[i] = ex; m_fg[i] = dout[i]; end
          end
        end
      end
      #1;
      for (int i = 0; i < 2; i++) begin
        if (!m_armed[i])                           xs = 3'b001;
        else if (edge_n < m_arm[i] + m_d[i] + 1)   xs = 3'b010;
        else                                       xs = 3'b100;
        check(i == 0 ? "add.state" : "sub.state", 64'(st[i]), 64'(xs));
        check(i == 0 ? "add.checks" : "sub.checks", 64'(cc[i]), 64'(m_cc[i]));
        check(i == 0 ? "add.errors" : "sub.errors", 64'(ec[i]), 64'(m_ec[i]));
        check(i == 0 ? "add.pass" : "sub.pass", 64'(pass[i]),
              64'((m_cc[i] >= 32'd1024) && (m_ec[i] == 16'd0)));
        check(i == 0 ? "add.fail" : "sub.fail", 64'(fl[i]), 64'(m_fl[i]));
        check(i == 0 ? "add.first_exp" : "sub.first_exp", 64'(fe[i]), 64'(m_fe[i]));
        check(i == 0 ? "add.first_got" : "sub.first_got", 64'(fg[i]), 64'(m_fg[i]));
      end
      edge_n++;
    end
  end

  // Fake DUT: returns the true result of operands driven tdly edges earlier.
  int unsigned  tdly = 0;
  logic [W-1:0] sa [16];
  logic [W-1:0] sb [16];
  bit           corrupt_en [2];
  logic [W-1:0] corrupt_val [2];
  bit           sat_mode = 0;

  task automatic cyc(input logic [W-1:0] na, input logic [W-1:0] nb);
    logic [3:0]   idx;
    logic [W-1:0] v;
    a = na; b = nb;
    sa[4'(edge_n)] = na;
    sb[4'(edge_n)] = nb;
    idx = 4'(edge_n + 16 - tdly);
    for (int i = 0; i < 2; i++) begin
      v = ref_op(i, sa[idx], sb[idx]);
      if (corrupt_en[i]) begin v = corrupt_val[i]; corrupt_en[i] = 0; end
      if (sat_mode) v = ~v;
      dout[i] = v;
    end
    @(negedge clk_dut);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) begin sa[i] = '0; sb[i] = '0; end
    corrupt_en[0] = 0; corrupt_en[1] = 0;
    corrupt_val[0] = '0; corrupt_val[1] = '0;
    dout[0] = '0; dout[1] = '0;
    reset = 1'b1; dly = UNK; tdly = 0;

    repeat (3) cyc(32'd3, 32'd5);
    check("rst.state", 64'(st[0]), 64'(3'b001));
    check("rst.checks", 64'(cc[0]), 64'd0);
    check("rst.fail", 64'(fl[0]), 64'd0);

    // D=2 ideal adder: held operands, then random traffic
    reset = 1'b0; dly = 4'd2; tdly = 2;
    repeat (3) cyc(32'd3, 32'd5);
    check("d2.fill_state", 64'(st[0]), 64'(3'b010));
    check("d2.no_check_yet", 64'(cc[0]), 64'd0);
    cyc(32'd3, 32'd5);
    check("d2.first_check", 64'(cc[0]), 64'd1);
    check("d2.check_state", 64'(st[0]), 64'(3'b100));
    repeat (1030) cyc($urandom, $urandom);
    check("d2.pass", 64'(pass[0]), 64'd1);
    check("d2.errors", 64'(ec[0]), 64'd0);
    check("d2.nofail", 64'(fl[0]), 64'd0);

    // D=0 subtractor: first compare one edge after FILL entry expects 10-3=7
    dly = UNK; cyc(32'd10, 32'd3);
    check("d0.idle", 64'(st[1]), 64'(3'b001));
    dly = 4'd0; tdly = 0; cyc(32'd10, 32'd3);
    check("d0.fill", 64'(st[1]), 64'(3'b010));
    corrupt_en[1] = 1; corrupt_val[1] = 32'h0000_1234; cyc(32'd10, 32'd3);
    check("d0.first_exp", 64'(fe[1]), 64'h7);
    check("d0.first_got", 64'(fg[1]), 64'h1234);
    repeat (5) cyc(32'd10, 32'd3);
    check("d0.single_error", 64'(ec[1]), 64'd1);

    // D=3 adder: one corrupted output, then a second one
    dly = UNK; cyc(32'd3, 32'd5);
    dly = 4'd3; tdly = 3;
    repeat (8) cyc(32'd3, 32'd5);
    check("d3.clean", 64'(ec[0]), 64'd0);
    corrupt_en[0] = 1; corrupt_val[0] = 32'hDEAD_BEEF; cyc(32'd3, 32'd5);
    check("d3.fail", 64'(fl[0]), 64'd1);
    check("d3.errors1", 64'(ec[0]), 64'd1);
    check("d3.first_exp", 64'(fe[0]), 64'd8);
    check("d3.first_got", 64'(fg[0]), 64'hDEAD_BEEF);
    check("d3.pass_drop", 64'(pass[0]), 64'd0);
    repeat (3) cyc(32'd3, 32'd5);
    corrupt_en[0] = 1; corrupt_val[0] = 32'h0; cyc(32'd3, 32'd5);
    check("d3.errors2", 64'(ec[0]), 64'd2);
    check("d3.keep_exp", 64'(fe[0]), 64'd8);
    check("d3.keep_got", 64'(fg[0]), 64'hDEAD_BEEF);

    // delay unknown for 100 cycles, then D=5
    reset = 1'b1; dly = UNK; cyc(32'd3, 32'd5);
    reset = 1'b0;
    repeat (100) cyc($urandom, $urandom);
    check("unk.idle", 64'(st[0]), 64'(3'b001));
    check("unk.checks", 64'(cc[0]), 64'd0);
    dly = 4'd5; tdly = 5;
    repeat (6) cyc($urandom, $urandom);
    check("d5.no_check_yet", 64'(cc[0]), 64'd0);
    cyc($urandom, $urandom);
    check("d5.first_check", 64'(cc[0]), 64'd1);

    // D=2 in CHECK, then change to 4 mid-CHECK
    dly = 4'd2; tdly = 2;
    repeat (15) cyc($urandom, $urandom);
    check("d2b.checks", 64'(cc[0]), 64'd12);
    dly = 4'd4; tdly = 4; cyc($urandom, $urandom);
    check("chg.idle", 64'(st[0]), 64'(3'b001));
    check("chg.kept", 64'(cc[0]), 64'd12);
    repeat (5) cyc($urandom, $urandom);
    check("chg.refill", 64'(st[0]), 64'(3'b010));
    cyc($urandom, $urandom);
    repeat (20) cyc($urandom, $urandom);
    check("chg.checks", 64'(cc[0]), 64'd33);
    check("chg.errors", 64'(ec[0]), 64'd0);

    // reset on the same edge as a mismatch
    corrupt_en[0] = 1; corrupt_val[0] = 32'hBAD0_0BAD; reset = 1'b1;
    cyc($urandom, $urandom);
    reset = 1'b0;
    check("rstm.state", 64'(st[0]), 64'(3'b001));
    check("rstm.errors", 64'(ec[0]), 64'd0);
    check("rstm.fail", 64'(fl[0]), 64'd0);
    check("rstm.first_got", 64'(fg[0]), 64'd0);

    // continuous mismatches until the error counter saturates
    dly = 4'd1; tdly = 1; sat_mode = 1;
    repeat (65545) cyc(32'd7, 32'd9);
    check("sat.errors", 64'(ec[0]), 64'hFFFF);
    check("sat.fail", 64'(fl[0]), 64'd1);
    check("sat.checks", 64'(cc[0]), 64'd65543);
    check("sat.first_exp", 64'(fe[0]), 64'd16);
    check("sat.first_got", 64'(fg[0]), 64'hFFFF_FFEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
